// File: rtl/mem_access_unit.sv
// Load/store unit for a big-endian doubleword data memory. Sub-doubleword
// stores are done as read-modify-write; misaligned accesses fail fast with Err.
module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [63:0] Address,
  input  logic [63:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [63:0] LoadData,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWriteData,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  input  logic [63:0] MemReadData
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        sext;
    logic [2:0]  off;
    logic [63:0] sdata;
  } req_t;

  localparam logic [3:0] LAST_CNT = 4'(READ_LAT - 1);

  state_t     state;
  req_t       r;
  logic [3:0] wcnt;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 64'h0000_0000_0000_00ff;
      2'b01:   return 64'h0000_0000_0000_ffff;
      2'b10:   return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

  // Big-endian: the field's last byte sits (8 - off - bytes) bytes above bit 0.
  function automatic logic [6:0] field_shift(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] endb;
    endb = {1'b0, off} + (4'd1 << size);
    return 7'd64 - {endb, 3'b000};
  endfunction

  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return |off[1:0];
      default: return |off;
    endcase
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] dw, input req_t q);
    logic [63:0] raw;
    raw = (dw >> field_shift(q.off, q.size)) & size_mask(q.size);
    case (q.size)
      2'b00:   return q.sext ? {{56{raw[7]}},  raw[7:0]}  : raw;
      2'b01:   return q.sext ? {{48{raw[15]}}, raw[15:0]} : raw;
      2'b10:   return q.sext ? {{32{raw[31]}}, raw[31:0]} : raw;
      default: return raw;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] dw, input req_t q);
    logic [63:0] m;
    logic [63:0] d;
    m = size_mask(q.size) << field_shift(q.off, q.size);
    d = (q.sdata & size_mask(q.size)) << field_shift(q.off, q.size);
    return (dw & ~m) | (d & m);
  endfunction

  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state        <= IDLE;
      r            <= '0;
      wcnt         <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Err          <= 1'b0;
      MemoryRead   <= 1'b0;
      MemoryWrite  <= 1'b0;
      LoadData     <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            r <= '{store: IsStore, size: Size, sext: SignExt,
                   off: Address[2:0], sdata: StoreData};
            MemAddress <= {Address[63:3], 3'b000};
            Busy       <= 1'b1;
            if (misaligned(Address[2:0], Size)) begin
              Err   <= 1'b1;
              Done  <= 1'b1;
              state <= DONE;
            end else if (IsStore && Size == 2'b11) begin
              Err          <= 1'b0;
              MemWriteData <= StoreData;
              MemoryWrite  <= 1'b1;
              state        <= WR;
            end else begin
              Err        <= 1'b0;
              MemoryRead <= 1'b1;
              state      <= RD;
            end
          end
        end
        RD: begin
          MemoryRead <= 1'b0;
          wcnt       <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (wcnt == LAST_CNT) begin
            wcnt <= '0;
            if (r.store) begin
              MemWriteData <= merge(MemReadData, r);
              MemoryWrite  <= 1'b1;
              state        <= WR;
            end else begin
              LoadData <= extract(MemReadData, r);
              Done     <= 1'b1;
              state    <= DONE;
            end
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        WR: begin
          MemoryWrite <= 1'b0;
          Done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
